// File: rtl/param_updown_counter_pkg.sv
// Shared constants for the modulo-N up/down counter: direction encoding and
// the per-edge step classification used by the next-state logic.
package param_updown_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_LOAD = 2'd1,
    STEP_UP   = 2'd2,
    STEP_DOWN = 2'd3
  } step_e;

endpackage

// File: rtl/param_updown_counter_if.sv
// Control/status bundle of the up/down counter. The controller owns the
// master side; the counter itself is the slave.
interface param_updown_counter_if #(
  parameter int WIDTH = 4
);
  logic             EN;
  logic             UP;
  logic             LOAD;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic             TC;
  logic             OVF;

  modport master (output EN, output UP, output LOAD, output D,
                  input  Q,  input  TC, input  OVF);
  modport slave  (input  EN, input  UP, input  LOAD, input  D,
                  output Q,  output TC, output OVF);
endinterface

// File: rtl/param_updown_counter.sv
// Parametrised modulo-N up/down counter with load, wrap/saturate boundary
// behaviour, combinational terminal count and a registered overflow pulse.
module param_updown_counter
  import param_updown_counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int SATURATE = 0
) (
  input  logic                  CLOCK,
  input  logic                  CLEAR,
  param_updown_counter_if.slave bus
);

  localparam longint unsigned SPAN = 64'd1 << WIDTH;
  localparam logic [WIDTH-1:0] MAX  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam bit               SAT  = (SATURATE != 0);

  generate
    if (WIDTH < 1 || WIDTH > 63 || MODULUS < 2 || longint'(MODULUS) > SPAN) begin : g_bad_params
      $error("param_updown_counter: need 2 <= MODULUS <= 2**WIDTH");
    end
  endgenerate

  logic [WIDTH-1:0] r_q;
  logic             r_ovf;
  logic [WIDTH-1:0] w_q_next;
  logic             w_ovf_next;
  logic             w_at_max;
  logic             w_at_zero;
  step_e            w_step;

  assign w_at_max  = (r_q == MAX);
  assign w_at_zero = (r_q == ZERO);

  // Classify this edge: load wins over counting, counting over holding.
  always_comb begin
    w_step = STEP_HOLD;
    if (bus.LOAD) begin
      w_step = STEP_LOAD;
    end else if (bus.EN) begin
      w_step = (bus.UP == DIR_UP) ? STEP_UP : STEP_DOWN;
    end else begin
      w_step = STEP_HOLD;
    end
  end

  // Next count and overflow; boundaries compare against MAX so any modulus behaves the same.
  always_comb begin
    w_q_next   = r_q;
    w_ovf_next = 1'b0;
    case (w_step)
      STEP_LOAD: begin
        w_q_next = (bus.D > MAX) ? MAX : bus.D;
      end
      STEP_UP: begin
        if (w_at_max) begin
          w_q_next   = SAT ? MAX : ZERO;
          w_ovf_next = 1'b1;
        end else begin
          w_q_next = r_q + ONE;
        end
      end
      STEP_DOWN: begin
        if (w_at_zero) begin
          w_q_next   = SAT ? ZERO : MAX;
          w_ovf_next = 1'b1;
        end else begin
          w_q_next = r_q - ONE;
        end
      end
      STEP_HOLD: begin
        w_q_next = r_q;
      end
      default: begin
        w_q_next = r_q;
      end
    endcase
  end

  // Count and overflow registers, cleared asynchronously by CLEAR.
  always_ff @(posedge CLOCK or negedge CLEAR) begin
    if (!CLEAR) begin
      r_q   <= ZERO;
      r_ovf <= 1'b0;
    end else begin
      r_q   <= w_q_next;
      r_ovf <= w_ovf_next;
    end
  end

  // TC anticipates the edge that will raise OVF, so it can enable the next stage.
  assign bus.TC  = ((w_step == STEP_UP) && w_at_max) || ((w_step == STEP_DOWN) && w_at_zero);
  assign bus.Q   = r_q;
  assign bus.OVF = r_ovf;

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed, table-driven bench for param_updown_counter: a wrapping MOD-10,
// a saturating MOD-10 and a full-range MOD-16 instance share clock and clear.
module tb_param_updown_counter;

  logic CLOCK;
  logic CLEAR;

  param_updown_counter_if #(.WIDTH(4)) u_if_a ();
  param_updown_counter_if #(.WIDTH(4)) u_if_b ();
  param_updown_counter_if #(.WIDTH(4)) u_if_c ();

  param_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_dut_a (
    .CLOCK(CLOCK), .CLEAR(CLEAR), .bus(u_if_a.slave));
  param_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_dut_b (
    .CLOCK(CLOCK), .CLEAR(CLEAR), .bus(u_if_b.slave));
  param_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) u_dut_c (
    .CLOCK(CLOCK), .CLEAR(CLEAR), .bus(u_if_c.slave));

  typedef struct {
    int         sel;
    bit         en;
    bit         up;
    bit         load;
    logic [3:0] d;
    bit         tc;
    logic [3:0] q;
    bit         ovf;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  initial CLOCK = 1'b0;
  always #10 CLOCK = ~CLOCK;

  function automatic void add(int sel, bit en, bit up, bit load, int d, bit tc, int q, bit ovf);
    vec_t v;
    v.sel = sel; v.en = en; v.up = up; v.load = load; v.d = 4'(d);
    v.tc = tc; v.q = 4'(q); v.ovf = ovf;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input bit en, input bit up, input bit load, input logic [3:0] d);
    case (sel)
      0: begin u_if_a.EN = en; u_if_a.UP = up; u_if_a.LOAD = load; u_if_a.D = d; end
      1: begin u_if_b.EN = en; u_if_b.UP = up; u_if_b.LOAD = load; u_if_b.D = d; end
      default: begin u_if_c.EN = en; u_if_c.UP = up; u_if_c.LOAD = load; u_if_c.D = d; end
    endcase
  endtask

  // Packs {Q, TC, OVF} of the selected instance.
  function automatic logic [5:0] obs(input int sel);
    case (sel)
      0: return {u_if_a.Q, u_if_a.TC, u_if_a.OVF};
      1: return {u_if_b.Q, u_if_b.TC, u_if_b.OVF};
      default: return {u_if_c.Q, u_if_c.TC, u_if_c.OVF};
    endcase
  endfunction

  initial begin
    logic [5:0] o;

    // Instance A, wrapping MOD-10: count-up from reset, wrap at 9.
    for (int k = 0; k < 9; k++) add(0, 1, 1, 0, 0, 0, k + 1, 0);
    add(0, 1, 1, 0, 0, 1, 0, 1);
    add(0, 1, 1, 0, 0, 0, 1, 0);
    // Down count through zero.
    add(0, 0, 0, 1, 2, 0, 2, 0);
    add(0, 1, 0, 0, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1, 9, 1);
    add(0, 1, 0, 0, 0, 0, 8, 0);
    // Direction change on consecutive edges.
    add(0, 1, 1, 0, 0, 0, 9, 0);
    add(0, 1, 0, 0, 0, 0, 8, 0);
    add(0, 1, 1, 0, 0, 0, 9, 0);
    // Load beats enable (TC suppressed at MAX), clamp of out-of-range loads.
    add(0, 1, 1, 1, 7, 0, 7, 0);
    add(0, 1, 1, 1, 12, 0, 9, 0);
    add(0, 1, 1, 1, 15, 0, 9, 0);
    add(0, 1, 1, 0, 0, 1, 0, 1);
    add(0, 0, 1, 0, 0, 0, 0, 0);
    // Hold.
    add(0, 0, 1, 1, 4, 0, 4, 0);
    add(0, 0, 1, 0, 0, 0, 4, 0);
    add(0, 0, 0, 0, 0, 0, 4, 0);
    add(0, 1, 1, 1, 5, 0, 5, 0);
    // Instance B, saturating MOD-10.
    add(1, 0, 1, 1, 8, 0, 8, 0);
    add(1, 1, 1, 0, 0, 0, 9, 0);
    add(1, 1, 1, 0, 0, 1, 9, 1);
    add(1, 1, 1, 0, 0, 1, 9, 1);
    add(1, 1, 1, 0, 0, 1, 9, 1);
    add(1, 1, 0, 0, 0, 0, 8, 0);
    add(1, 0, 0, 1, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 1, 0, 1);
    add(1, 1, 0, 0, 0, 1, 0, 1);
    add(1, 1, 1, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 1, 0);
    // Instance C, full-range MOD-16.
    add(2, 0, 1, 1, 15, 0, 15, 0);
    add(2, 1, 1, 0, 0, 1, 0, 1);
    add(2, 1, 0, 0, 0, 1, 15, 1);
    add(2, 1, 0, 0, 0, 0, 14, 0);
    add(2, 1, 1, 0, 0, 0, 15, 0);
    add(2, 1, 1, 0, 0, 1, 0, 1);

    CLEAR = 1'b0;
    drive(0, 1'b1, 1'b1, 1'b0, 4'd0);
    drive(1, 1'b0, 1'b1, 1'b0, 4'd0);
    drive(2, 1'b0, 1'b1, 1'b0, 4'd0);

    // Reset held across the edge at t=10.
    #20;
    for (int s = 0; s < 3; s++) begin
      o = obs(s);
      chk($sformatf("reset_q_%0d", s), o[5:2], 0);
      chk($sformatf("reset_ovf_%0d", s), o[0], 0);
    end
    #14;
    CLEAR = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].sel, vecs[i].en, vecs[i].up, vecs[i].load, vecs[i].d);
      #1;
      o = obs(vecs[i].sel);
      chk($sformatf("v%0d_tc", i), o[1], vecs[i].tc);
      @(posedge CLOCK);
      #1;
      o = obs(vecs[i].sel);
      chk($sformatf("v%0d_q", i), o[5:2], vecs[i].q);
      chk($sformatf("v%0d_ovf", i), o[0], vecs[i].ovf);
    end

    // Async clear mid-count: A sits at 5, C has OVF high.
    drive(0, 1'b1, 1'b1, 1'b1, 4'd3);
    #4;
    CLEAR = 1'b0;
    #1;
    o = obs(0);
    chk("clr_now_q_a", o[5:2], 0);
    chk("clr_now_ovf_a", o[0], 0);
    o = obs(2);
    chk("clr_now_q_c", o[5:2], 0);
    chk("clr_now_ovf_c", o[0], 0);
    @(posedge CLOCK);
    #1;
    o = obs(0);
    chk("clr_held_q_a", o[5:2], 0);
    chk("clr_held_ovf_a", o[0], 0);
    #4;
    CLEAR = 1'b1;
    @(posedge CLOCK);
    #1;
    o = obs(0);
    chk("clr_rel_q_a", o[5:2], 3);
    chk("clr_rel_ovf_a", o[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
